// File: rtl/engine_job_scheduler_if.sv
// Requester/engine side signals of the job scheduler.
// The master modport drives requests and engine state; the slave is the scheduler.
interface engine_job_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] err;
    logic               eng_start;
    logic [3:0]         eng_state;
    logic               busy;
    logic [CNT_W-1:0]   job_count;
    logic [7:0]         timeout_count;

    modport master (
        output req,
        output eng_state,
        input  grant,
        input  grant_id,
        input  done,
        input  err,
        input  eng_start,
        input  busy,
        input  job_count,
        input  timeout_count
    );

    modport slave (
        input  req,
        input  eng_state,
        output grant,
        output grant_id,
        output done,
        output err,
        output eng_start,
        output busy,
        output job_count,
        output timeout_count
    );
endinterface

// File: rtl/engine_job_scheduler.sv
// Round-robin sharing of one load/process/save engine between NUM_REQ requesters,
// with a grant-to-idle watchdog that flushes stuck jobs.
module engine_job_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input logic                   clk,
    input logic                   rst,
    engine_job_scheduler_if.slave bus
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] EngIdle = 4'd0;
    localparam logic [3:0] EngLoad = 4'd1;
    localparam logic [3:0] EngDone = 4'd4;

    typedef enum logic [2:0] {StIdle, StStart, StRun, StRelease, StDone, StFlush} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   job_q, job_d;
    logic [7:0]         tcount_q, tcount_d;
    logic [NUM_REQ-1:0] err_q, err_d;

    logic [ID_W:0]      win;
    logic [ID_W-1:0]    next_ptr;
    logic [NUM_REQ-1:0] id_onehot;
    logic               active;

    // Offsets are scanned from farthest to nearest so the nearest set bit wins.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    p);
        logic [ID_W:0] res;
        int            c;
        res = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            c = int'(p) + i;
            if (c >= int'(NUM_REQ)) c = c - int'(NUM_REQ);
            if (r[c]) res = {1'b1, c[ID_W-1:0]};
        end
        return res;
    endfunction

    assign win       = rr_pick(bus.req, ptr_q);
    assign next_ptr  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
    assign id_onehot = NUM_REQ'(1) << grant_id_q;
    assign active    = (state_q == StStart) || (state_q == StRun) || (state_q == StRelease);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            tmo_q      <= '0;
            job_q      <= '0;
            tcount_q   <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            tmo_q      <= tmo_d;
            job_q      <= job_d;
            tcount_q   <= tcount_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        tmo_d      = tmo_q;
        job_d      = job_q;
        tcount_d   = tcount_q;
        err_d      = '0;

        case (state_q)
            StIdle: begin
                if (bus.eng_state == EngIdle && win[ID_W]) begin
                    state_d    = StStart;
                    grant_d    = NUM_REQ'(1) << win[ID_W-1:0];
                    grant_id_d = win[ID_W-1:0];
                    tmo_d      = '0;
                end
            end
            StStart:   if (bus.eng_state == EngLoad) state_d = StRun;
            StRun:     if (bus.eng_state == EngDone) state_d = StRelease;
            StRelease: begin
                if (bus.eng_state == EngIdle) begin
                    state_d = StDone;
                    grant_d = '0;
                    job_d   = job_q + CNT_W'(1);
                    ptr_d   = next_ptr;
                end
            end
            StDone:  state_d = StIdle;
            StFlush: if (bus.eng_state == EngIdle) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Watchdog overrides whatever transition the case above chose.
        if (active) begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d  = StFlush;
                grant_d  = '0;
                job_d    = job_q;
                ptr_d    = next_ptr;
                err_d    = id_onehot;
                tcount_d = (tcount_q == 8'hFF) ? 8'hFF : tcount_q + 8'd1;
            end
        end
    end

    always_comb begin
        bus.grant         = grant_q;
        bus.grant_id      = grant_id_q;
        bus.err           = err_q;
        bus.done          = (state_q == StDone) ? id_onehot : '0;
        bus.eng_start     = (state_q == StStart) || (state_q == StRun);
        bus.busy          = (state_q != StIdle);
        bus.job_count     = job_q;
        bus.timeout_count = tcount_q;
    end
endmodule

// File: tb/tb_engine_job_scheduler.sv
// Bench for engine_job_scheduler: stub engine, round-robin/counter model,
// table-driven jobs, hand-written corner sequences and randomized jobs.
module tb_engine_job_scheduler;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TMO     = 16;
    localparam int unsigned CNT_W   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    engine_job_scheduler_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) sif ();

    engine_job_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Stub engine: phase lengths in lens[], optional hang in LOAD, optional
    // one-cycle illegal state 7 during PROCESS. Aborts to IDLE if start drops.
    int  lens[4] = '{1, 1, 1, 1};
    bit  stuck = 1'b0;
    int  glitch_set = 0;
    int  glitch_done = 0;
    int  e_st = 0;
    int  e_cnt = 0;
    bit  glitch_now;
    logic prev_start = 1'b0;
    logic [NUM_REQ-1:0] prev_grant = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if ((sif.done | sif.err) != '0) begin
                chk("pulse_onehot", $countones(sif.done | sif.err), 1);
                chk("start_low_at_pulse", sif.eng_start, 0);
            end
            if (sif.grant != '0 && prev_grant == '0) begin
                chk("grant_onehot", $countones(sif.grant), 1);
                chk("start_gap", prev_start, 0);
            end
        end
        prev_start = sif.eng_start;
        prev_grant = sif.grant;

        glitch_now = 1'b0;
        case (e_st)
            0: if (sif.eng_start) begin e_st = 1; e_cnt = lens[0]; end
            1, 2, 3: begin
                if (stuck) begin
                end else if (!sif.eng_start) begin
                    e_st = 0;
                end else if (e_st == 2 && glitch_set != glitch_done) begin
                    glitch_now = 1'b1;
                    glitch_done++;
                end else if (e_cnt > 1) begin
                    e_cnt--;
                end else begin
                    e_st++;
                    e_cnt = lens[e_st-1];
                end
            end
            default: begin
                if (e_cnt > 1) e_cnt--;
                else if (!sif.eng_start) e_st = 0;
            end
        endcase
        sif.eng_state = glitch_now ? 4'd7 : 4'(e_st);
    end

    // Reference model: scheduling rules expressed directly.
    int m_ptr = 0, m_jobs = 0, m_tmo = 0;

    function automatic int model_pick(input logic [3:0] r, input int p);
        int best = -1;
        int bestd = int'(NUM_REQ);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (r[i]) begin
                int d = (i - p + int'(NUM_REQ)) % int'(NUM_REQ);
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
        return best;
    endfunction

    task automatic model_done(input int id);
        m_jobs = (m_jobs + 1) % (1 << CNT_W);
        m_ptr  = (id + 1) % int'(NUM_REQ);
    endtask

    task automatic model_timeout(input int id);
        m_tmo = (m_tmo < 255) ? m_tmo + 1 : 255;
        m_ptr = (id + 1) % int'(NUM_REQ);
    endtask

    task automatic wait_grant(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            if (sif.grant != '0) ok = 1'b1;
        end
        if (!ok) chk("grant_wait_expired", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!sif.busy) ok = 1'b1;
        end
        if (!ok) chk("idle_wait_expired", 0, 1);
    endtask

    task automatic run_job(input logic [3:0] r, input int exp_id, input bit drop,
                           output int lat);
        bit   ok;
        bit   stable = 1'b1;
        logic ps;
        sif.req = r;
        wait_grant(lat, ok);
        if (!ok) return;
        chk("grant", sif.grant, 1 << exp_id);
        chk("grant_id", sif.grant_id, exp_id);
        ps = sif.eng_start;
        if (drop) begin
            @(negedge clk);
            sif.req = '0;
            ps = sif.eng_start;
        end
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (sif.done != '0 || sif.err != '0) ok = 1'b1;
            else begin
                if (sif.grant != 4'(1 << exp_id)) stable = 1'b0;
                ps = sif.eng_start;
            end
        end
        if (!ok) begin
            chk("done_wait_expired", 0, 1);
            return;
        end
        model_done(exp_id);
        chk("grant_stable", stable, 1);
        chk("start_low_before_done", ps, 0);
        chk("done", sif.done, 1 << exp_id);
        chk("no_err", sif.err, 0);
        chk("job_count", sif.job_count, m_jobs);
        chk("grant_cleared", sif.grant, 0);
        chk("grant_id_hold", sif.grant_id, exp_id);
    endtask

    task automatic run_timeout(input logic [3:0] r, input int exp_id);
        int lat;
        int n = 0;
        bit ok;
        stuck   = 1'b1;
        sif.req = r;
        wait_grant(lat, ok);
        if (!ok) return;
        chk("tmo_grant", sif.grant, 1 << exp_id);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (sif.err != '0 || sif.done != '0) ok = 1'b1;
        end
        if (!ok) begin
            chk("err_wait_expired", 0, 1);
            return;
        end
        model_timeout(exp_id);
        chk("err_latency", n, TMO);
        chk("err", sif.err, 1 << exp_id);
        chk("no_done", sif.done, 0);
        chk("tmo_start_low", sif.eng_start, 0);
        chk("timeout_count", sif.timeout_count, m_tmo);
        @(negedge clk);
        chk("err_one_cycle", sif.err, 0);
    endtask

    typedef struct {
        logic [3:0] req;
        int         l0, l1, l2, l3;
        int         exp_id;
        int         exp_lat;
        int         exp_jobs;
    } vec_t;

    initial begin
        vec_t       vecs[8];
        int         lat;
        int         ng;
        int         id;
        bit         ok;
        logic [3:0] r;

        vecs[0] = '{4'b0001, 1, 2, 3, 4, 0, 1, 1};
        vecs[1] = '{4'b0001, 2, 1, 1, 2, 0, 2, 2};
        vecs[2] = '{4'b1001, 1, 1, 2, 1, 3, 2, 3};
        vecs[3] = '{4'b0110, 3, 1, 1, 1, 1, 2, 4};
        vecs[4] = '{4'b0110, 1, 3, 1, 3, 2, 2, 5};
        vecs[5] = '{4'b0011, 2, 2, 2, 2, 0, 2, 6};
        vecs[6] = '{4'b1100, 1, 1, 3, 1, 2, 2, 7};
        vecs[7] = '{4'b1010, 3, 3, 1, 2, 3, 2, 8};

        rst     = 1'b1;
        sif.req = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", sif.grant, 0);
        chk("rst_grant_id", sif.grant_id, 0);
        chk("rst_done", sif.done, 0);
        chk("rst_err", sif.err, 0);
        chk("rst_eng_start", sif.eng_start, 0);
        chk("rst_busy", sif.busy, 0);
        chk("rst_job_count", sif.job_count, 0);
        chk("rst_timeout_count", sif.timeout_count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[k]) begin
            lens = '{vecs[k].l0, vecs[k].l1, vecs[k].l2, vecs[k].l3};
            run_job(vecs[k].req, vecs[k].exp_id, 1'b0, lat);
            chk("vec_latency", lat, vecs[k].exp_lat);
            chk("vec_job_count", sif.job_count, vecs[k].exp_jobs);
        end

        // All requesters held: strict rotation; 16th job wraps the 4-bit counter.
        lens = '{1, 2, 1, 1};
        for (int k = 0; k < 8; k++) run_job(4'b1111, k % 4, 1'b0, lat);
        chk("job_count_wrap0", sif.job_count, 0);

        // Request dropped after grant plus an illegal engine state mid-job.
        glitch_set++;
        run_job(4'b0100, 2, 1'b1, lat);
        chk("drop_job_count", sif.job_count, 1);
        chk("drop_grant_id", sif.grant_id, 2);

        // Hung engine: timeout, then no grant while the engine stays busy.
        id = model_pick(4'b0010, m_ptr);
        run_timeout(4'b0010, id);
        ng = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sif.grant != '0) ng++;
        end
        chk("flush_no_grant", ng, 0);
        chk("flush_busy", sif.busy, 1);
        sif.req = '0;
        stuck   = 1'b0;
        wait_idle();

        for (int k = 0; k < 30; k++) begin
            r = 4'($urandom_range(1, 15));
            for (int j = 0; j < 4; j++) lens[j] = int'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) glitch_set++;
            id = model_pick(r, m_ptr);
            run_job(r, id, 1'($urandom_range(0, 1)), lat);
        end

        // Asynchronous reset in the middle of PROCESS.
        lens    = '{3, 3, 3, 3};
        sif.req = 4'b0001;
        wait_grant(lat, ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (sif.eng_state == 4'd2) ok = 1'b1;
        end
        if (!ok) chk("process_wait_expired", 0, 1);
        rst = 1'b1;
        #1;
        chk("midrst_grant", sif.grant, 0);
        chk("midrst_eng_start", sif.eng_start, 0);
        chk("midrst_busy", sif.busy, 0);
        chk("midrst_job_count", sif.job_count, 0);
        chk("midrst_timeout_count", sif.timeout_count, 0);
        chk("midrst_grant_id", sif.grant_id, 0);
        m_ptr   = 0;
        m_jobs  = 0;
        m_tmo   = 0;
        sif.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_job(4'b0010, model_pick(4'b0010, m_ptr), 1'b0, lat);

        // Enough timeouts to saturate the 8-bit timeout counter.
        for (int k = 0; k < 260; k++) begin
            r  = 4'($urandom_range(1, 15));
            id = model_pick(r, m_ptr);
            run_timeout(r, id);
            sif.req = '0;
            stuck   = 1'b0;
            wait_idle();
        end
        chk("timeout_saturated", sif.timeout_count, 255);
        chk("job_count_after_tmo", sif.job_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
